// File: rtl/axi_mem_model.sv
// AXI-style slave memory model: {tag, data} line array with in-order, fixed-latency,
// multi-outstanding reads, field-select writes and a single-entry B response register.
module axi_mem_model #(
    parameter int ID_W     = 16,
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 512,
    parameter int TAG_W    = 64,
    parameter int ADDR_LSB = 6,
    parameter int IDX_W    = 10,
    parameter int RD_LAT   = 4,
    parameter int OSTD     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ID_W-1:0]          arid_i,
    input  logic [ADDR_W-1:0]        araddr_i,
    input  logic                     arvalid_i,
    output logic                     arready_o,
    output logic [ID_W-1:0]          rid_o,
    output logic [TAG_W+DATA_W-1:0]  rdata_o,
    output logic                     rvalid_o,
    input  logic                     rready_i,
    input  logic [ID_W-1:0]          awid_i,
    input  logic [ADDR_W-1:0]        awaddr_i,
    input  logic                     awvalid_i,
    output logic                     awready_o,
    input  logic [TAG_W-1:0]         wtag_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic [1:0]               wsel_i,
    input  logic                     wvalid_i,
    output logic                     wready_o,
    output logic [ID_W-1:0]          bid_o,
    output logic                     bvalid_o,
    input  logic                     bready_i
);
    localparam int LINE_W = TAG_W + DATA_W;
    localparam int DEPTH  = 1 << IDX_W;
    localparam int PTR_W  = (OSTD > 1) ? $clog2(OSTD) : 1;
    localparam int QSZ    = 1 << PTR_W;
    localparam int OCNT_W = $clog2(OSTD + 1);
    localparam int LAT_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    logic [TAG_W-1:0]  tag_mem  [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic [ID_W-1:0]   q_id   [QSZ];
    logic [LINE_W-1:0] q_line [QSZ];
    logic [LAT_W-1:0]  q_lat  [QSZ];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [OCNT_W-1:0] q_count;

    logic              aw_full, w_full, b_full;
    logic [ID_W-1:0]   aw_id, b_id;
    logic [IDX_W-1:0]  aw_idx;
    logic [TAG_W-1:0]  w_tag;
    logic [DATA_W-1:0] w_data;
    logic [1:0]        w_sel;

    logic [IDX_W-1:0]  ar_idx;
    logic              ar_hs, r_pop, b_pop, commit;

    // Aliasing is intended: address bits outside the index field are ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{araddr_i[ADDR_W-1:ADDR_LSB+IDX_W], araddr_i[ADDR_LSB-1:0],
                                awaddr_i[ADDR_W-1:ADDR_LSB+IDX_W], awaddr_i[ADDR_LSB-1:0]};

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OSTD - 1)) ? '0 : p + 1'b1;
    endfunction

    assign ar_idx    = araddr_i[ADDR_LSB +: IDX_W];
    assign rvalid_o  = (q_count != '0) && (q_lat[rd_ptr] == '0);
    assign rid_o     = q_id[rd_ptr];
    assign rdata_o   = q_line[rd_ptr];
    assign r_pop     = rvalid_o && rready_i;
    assign arready_o = !rst && ((q_count < OCNT_W'(OSTD)) || r_pop);
    assign ar_hs     = arvalid_i && arready_o;

    assign awready_o = !rst && !aw_full;
    assign wready_o  = !rst && !w_full;
    assign bvalid_o  = b_full;
    assign bid_o     = b_id;
    assign b_pop     = b_full && bready_i;
    assign commit    = aw_full && w_full && (!b_full || b_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
            for (int i = 0; i < QSZ; i++) begin
                q_id[i]   <= '0;
                q_line[i] <= '0;
                q_lat[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < QSZ; i++) begin
                if (q_lat[i] != '0) q_lat[i] <= q_lat[i] - 1'b1;
            end
            // NOTE: non-blocking reads of the line array see the pre-commit value,
            // and this push overrides the decrement above for the slot it fills.
            if (ar_hs) begin
                q_id[wr_ptr]   <= arid_i;
                q_line[wr_ptr] <= {tag_mem[ar_idx], data_mem[ar_idx]};
                q_lat[wr_ptr]  <= LAT_W'(RD_LAT - 1);
                wr_ptr         <= ptr_next(wr_ptr);
            end
            if (r_pop) rd_ptr <= ptr_next(rd_ptr);
            if (ar_hs && !r_pop)      q_count <= q_count + 1'b1;
            else if (!ar_hs && r_pop) q_count <= q_count - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_full <= 1'b0;
            aw_id   <= '0;
            aw_idx  <= '0;
            w_full  <= 1'b0;
            w_tag   <= '0;
            w_data  <= '0;
            w_sel   <= '0;
            b_full  <= 1'b0;
            b_id    <= '0;
        end else begin
            if (awvalid_i && awready_o) begin
                aw_full <= 1'b1;
                aw_id   <= awid_i;
                aw_idx  <= awaddr_i[ADDR_LSB +: IDX_W];
            end else if (commit) begin
                aw_full <= 1'b0;
            end
            if (wvalid_i && wready_o) begin
                w_full <= 1'b1;
                w_tag  <= wtag_i;
                w_data <= wdata_i;
                w_sel  <= wsel_i;
            end else if (commit) begin
                w_full <= 1'b0;
            end
            if (commit) begin
                b_full <= 1'b1;
                b_id   <= aw_id;
            end else if (b_pop) begin
                b_full <= 1'b0;
            end
        end
    end

    // NOTE: the line array has no reset; it models DRAM contents that survive a controller reset.
    always_ff @(posedge clk) begin
        if (commit) begin
            if (w_sel[0]) data_mem[aw_idx] <= w_data;
            if (w_sel[1]) tag_mem[aw_idx]  <= w_tag;
        end
    end

endmodule

// File: tb/tb_axi_mem_model.sv
// Directed bench for axi_mem_model: default build plus an RD_LAT=1/OSTD=1 build for streaming.
module tb_axi_mem_model;
    localparam int ID_W   = 16;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 512;
    localparam int TAG_W  = 64;
    localparam int LINE_W = TAG_W + DATA_W;
    localparam int RD_LAT = 4;

    localparam logic [LINE_W-1:0] LINE1 = {64'hc0000003c0000000, {DATA_W{1'b1}}};
    localparam logic [LINE_W-1:0] LINE55 = {72{8'h55}};

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [ID_W-1:0]   arid, rid, awid, bid;
    logic [ADDR_W-1:0] araddr, awaddr;
    logic              arvalid, arready, rvalid, rready;
    logic              awvalid, awready, wvalid, wready, bvalid, bready;
    logic [LINE_W-1:0] rdata;
    logic [TAG_W-1:0]  wtag;
    logic [DATA_W-1:0] wdata;
    logic [1:0]        wsel;

    logic [ID_W-1:0]   f_arid, f_rid, f_bid;
    logic [ADDR_W-1:0] f_araddr;
    logic              f_arvalid, f_arready, f_rvalid, f_rready;
    logic              f_awready, f_wready, f_bvalid;
    logic [LINE_W-1:0] f_rdata;

    int total = 0;
    int bad = 0;

    axi_mem_model u_dut (
        .clk(clk), .rst(rst),
        .arid_i(arid), .araddr_i(araddr), .arvalid_i(arvalid), .arready_o(arready),
        .rid_o(rid), .rdata_o(rdata), .rvalid_o(rvalid), .rready_i(rready),
        .awid_i(awid), .awaddr_i(awaddr), .awvalid_i(awvalid), .awready_o(awready),
        .wtag_i(wtag), .wdata_i(wdata), .wsel_i(wsel), .wvalid_i(wvalid), .wready_o(wready),
        .bid_o(bid), .bvalid_o(bvalid), .bready_i(bready)
    );

    axi_mem_model #(.RD_LAT(1), .OSTD(1)) u_fast (
        .clk(clk), .rst(rst),
        .arid_i(f_arid), .araddr_i(f_araddr), .arvalid_i(f_arvalid), .arready_o(f_arready),
        .rid_o(f_rid), .rdata_o(f_rdata), .rvalid_o(f_rvalid), .rready_i(f_rready),
        .awid_i('0), .awaddr_i('0), .awvalid_i(1'b0), .awready_o(f_awready),
        .wtag_i('0), .wdata_i('0), .wsel_i(2'b00), .wvalid_i(1'b0), .wready_o(f_wready),
        .bid_o(f_bid), .bvalid_o(f_bvalid), .bready_i(1'b0)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                            input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data,
                            input logic [1:0] sel);
        bit done;
        bit aw_hit, w_hit;
        done = 1'b0;
        awid = id; awaddr = addr; wtag = tag; wdata = data; wsel = sel;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        for (int n = 0; n < 30 && !done; n++) begin
            @(negedge clk);
            if (bvalid) begin
                total++;
                if (bid !== id) begin bad++; $display("FAIL write_bid: got %h want %h", bid, id); end
                done = 1'b1;
            end
            aw_hit = awvalid && awready;
            w_hit  = wvalid && wready;
            step();
            if (aw_hit) awvalid = 1'b0;
            if (w_hit)  wvalid = 1'b0;
        end
        if (!done) begin total++; bad++; $display("FAIL write_timeout: no bvalid for id %h", id); end
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
    endtask

    task automatic do_read(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                           input logic [LINE_W-1:0] exp);
        bit done;
        bit hit;
        done = 1'b0;
        arid = id; araddr = addr; arvalid = 1'b1; rready = 1'b1;
        for (int n = 0; n < 30 && !done; n++) begin
            @(negedge clk);
            if (rvalid) begin
                total++;
                if (rid !== id) begin bad++; $display("FAIL read_rid: got %h want %h", rid, id); end
                total++;
                if (rdata !== exp) begin bad++; $display("FAIL read_data: got %h want %h", rdata, exp); end
                done = 1'b1;
            end
            hit = arvalid && arready;
            step();
            if (hit) arvalid = 1'b0;
        end
        if (!done) begin total++; bad++; $display("FAIL read_timeout: no rvalid for id %h", id); end
        arvalid = 1'b0; rready = 1'b0;
    endtask

    task automatic test_reset();
        arvalid = 0; rready = 0; awvalid = 0; wvalid = 0; bready = 0;
        arid = '0; araddr = '0; awid = '0; awaddr = '0; wtag = '0; wdata = '0; wsel = '0;
        f_arvalid = 0; f_rready = 0; f_arid = '0; f_araddr = '0;
        #1 rst = 1'b1;
        #2;
        total++;
        if ({arready, awready, wready, rvalid, bvalid} !== 5'b0) begin
            bad++; $display("FAIL reset_ctrl: got %b want 00000", {arready, awready, wready, rvalid, bvalid});
        end
        total++;
        if ({rid, bid, rdata} !== '0) begin bad++; $display("FAIL reset_data: rid=%h bid=%h nonzero", rid, bid); end
        total++;
        if ({f_arready, f_rvalid, f_bvalid} !== 3'b0) begin
            bad++; $display("FAIL reset_fast: got %b want 000", {f_arready, f_rvalid, f_bvalid});
        end
        step(); step();
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({arready, awready, wready} !== 3'b111) begin
            bad++; $display("FAIL reset_release_ready: got %b want 111", {arready, awready, wready});
        end
        step();
    endtask

    task automatic test_field_write_latency();
        do_write(16'h0001, 64'h40, 64'hc0000003c0000000, {16{32'hdeadbeef}}, 2'b10);
        do_write(16'h0002, 64'h40, 64'h1111, {DATA_W{1'b1}}, 2'b01);
        arid = 16'h00a5; araddr = 64'h40; arvalid = 1'b1; rready = 1'b1;
        @(negedge clk);
        total++;
        if (arready !== 1'b1) begin bad++; $display("FAIL lat_arready: got %b want 1", arready); end
        step();
        arvalid = 1'b0;
        for (int k = 1; k <= RD_LAT; k++) begin
            @(negedge clk);
            total++;
            if (rvalid !== (k == RD_LAT)) begin
                bad++; $display("FAIL lat_rvalid cycle %0d: got %b want %b", k, rvalid, k == RD_LAT);
            end
            if (k == RD_LAT) begin
                total++;
                if (rid !== 16'h00a5) begin bad++; $display("FAIL lat_rid: got %h want 00a5", rid); end
                total++;
                if (rdata !== LINE1) begin bad++; $display("FAIL lat_rdata: got %h want %h", rdata, LINE1); end
            end
            step();
        end
        @(negedge clk);
        total++;
        if (rvalid !== 1'b0) begin bad++; $display("FAIL lat_single_beat: got %b want 0", rvalid); end
        step();
        rready = 1'b0;
    endtask

    task automatic test_outstanding();
        logic [ID_W-1:0] ids[$];
        int cyc[$];
        bit hit;
        rready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            arid = ID_W'(k); araddr = ADDR_W'(k) << 6; arvalid = 1'b1;
            @(negedge clk);
            total++;
            if (arready !== 1'b1) begin bad++; $display("FAIL ostd_accept %0d: got %b want 1", k, arready); end
            step();
        end
        arid = 16'd5; araddr = 64'd5 << 6;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++;
            if (arready !== 1'b0) begin bad++; $display("FAIL ostd_full %0d: got %b want 0", k, arready); end
            if (k == 3) begin
                total++;
                if ({rvalid, rid} !== {1'b1, 16'd1}) begin
                    bad++; $display("FAIL ostd_hold: got %b/%h want 1/0001", rvalid, rid);
                end
            end
            step();
        end
        rready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 0) begin
                total++;
                if (arready !== 1'b1) begin bad++; $display("FAIL ostd_pop_through: got %b want 1", arready); end
            end
            if (rvalid) begin
                ids.push_back(rid);
                cyc.push_back(c);
                if (rid == 16'd1) begin
                    total++;
                    if (rdata !== LINE1) begin bad++; $display("FAIL ostd_data1: got %h want %h", rdata, LINE1); end
                end
            end
            hit = arvalid && arready;
            step();
            if (hit) arvalid = 1'b0;
        end
        arvalid = 1'b0;
        rready = 1'b0;
        total++;
        if (ids.size() != 5) begin bad++; $display("FAIL ostd_beats: got %0d want 5", ids.size()); end
        for (int i = 0; i < ids.size() && i < 5; i++) begin
            total++;
            if (ids[i] !== ID_W'(i + 1) || cyc[i] != i) begin
                bad++; $display("FAIL ostd_order %0d: got id %h at %0d want id %0d at %0d", i, ids[i], cyc[i], i + 1, i);
            end
        end
    endtask

    task automatic test_same_cycle_rw();
        logic [ID_W-1:0]   ids[$];
        logic [LINE_W-1:0] lines[$];
        bit b_seen, hit;
        b_seen = 1'b0;
        do_write(16'h0003, 64'd7 << 6, '0, '0, 2'b11);
        awid = 16'h0077; awaddr = 64'd7 << 6; wtag = {8{8'h55}}; wdata = {64{8'h55}}; wsel = 2'b11;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1; rready = 1'b1;
        @(negedge clk);
        total++;
        if ({awready, wready} !== 2'b11) begin bad++; $display("FAIL rw_aw_w_ready: got %b want 11", {awready, wready}); end
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        arid = 16'h0071; araddr = 64'd7 << 6; arvalid = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (c < 2) begin
                total++;
                if (arready !== 1'b1) begin bad++; $display("FAIL rw_arready %0d: got %b want 1", c, arready); end
            end
            if (bvalid) begin
                b_seen = 1'b1;
                total++;
                if (bid !== 16'h0077) begin bad++; $display("FAIL rw_bid: got %h want 0077", bid); end
            end
            if (rvalid) begin ids.push_back(rid); lines.push_back(rdata); end
            hit = arvalid && arready;
            step();
            if (c == 0) arid = 16'h0072;
            if (c == 1 || !hit) arvalid = (c == 0) ? arvalid : 1'b0;
        end
        arvalid = 1'b0; rready = 1'b0; bready = 1'b0;
        total++;
        if (!b_seen) begin bad++; $display("FAIL rw_bvalid: got none want one"); end
        total++;
        if (ids.size() != 2) begin
            bad++; $display("FAIL rw_beats: got %0d want 2", ids.size());
        end else begin
            total++;
            if ({ids[0], lines[0]} !== {16'h0071, {LINE_W{1'b0}}}) begin
                bad++; $display("FAIL rw_old: got %h/%h want 0071/0", ids[0], lines[0]);
            end
            total++;
            if ({ids[1], lines[1]} !== {16'h0072, LINE55}) begin
                bad++; $display("FAIL rw_new: got %h/%h want 0072/%h", ids[1], lines[1], LINE55);
            end
        end
    endtask

    task automatic test_wsel_none();
        do_write(16'h0099, 64'd7 << 6, {8{8'haa}}, {64{8'haa}}, 2'b00);
        do_read(16'h0098, 64'd7 << 6, LINE55);
    endtask

    task automatic test_b_backpressure();
        bready = 1'b0;
        wtag = 64'h1; wdata = 512'h1; wsel = 2'b11; wvalid = 1'b1;
        @(negedge clk);
        total++;
        if (wready !== 1'b1) begin bad++; $display("FAIL bp_w_accept: got %b want 1", wready); end
        step();
        wvalid = 1'b0;
        @(negedge clk);
        total++;
        if ({wready, awready} !== 2'b01) begin bad++; $display("FAIL bp_w_held: got %b want 01", {wready, awready}); end
        step();
        step();
        awid = 16'h1234; awaddr = 64'd9 << 6; awvalid = 1'b1;
        @(negedge clk);
        total++;
        if (awready !== 1'b1) begin bad++; $display("FAIL bp_aw_accept: got %b want 1", awready); end
        step();
        awvalid = 1'b0;
        @(negedge clk);
        total++;
        if (bvalid !== 1'b0) begin bad++; $display("FAIL bp_commit_cycle: got %b want 0", bvalid); end
        step();
        awid = 16'h5678; awaddr = 64'd10 << 6; wtag = 64'h2; wdata = 512'h2; wsel = 2'b11;
        awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        total++;
        if ({bvalid, bid, awready, wready} !== {1'b1, 16'h1234, 2'b11}) begin
            bad++; $display("FAIL bp_first_b: got %b/%h/%b want 1/1234/11", bvalid, bid, {awready, wready});
        end
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++;
            if ({bvalid, bid, awready, wready} !== {1'b1, 16'h1234, 2'b00}) begin
                bad++; $display("FAIL bp_stall %0d: got %b/%h/%b want 1/1234/00", k, bvalid, bid, {awready, wready});
            end
            step();
        end
        bready = 1'b1;
        @(negedge clk);
        total++;
        if ({bvalid, bid} !== {1'b1, 16'h1234}) begin bad++; $display("FAIL bp_release: got %b/%h want 1/1234", bvalid, bid); end
        step();
        @(negedge clk);
        total++;
        if ({bvalid, bid} !== {1'b1, 16'h5678}) begin bad++; $display("FAIL bp_second_b: got %b/%h want 1/5678", bvalid, bid); end
        step();
        @(negedge clk);
        total++;
        if ({bvalid, awready, wready} !== 3'b011) begin
            bad++; $display("FAIL bp_drain: got %b want 011", {bvalid, awready, wready});
        end
        bready = 1'b0;
        step();
        do_read(16'h0a10, 64'd10 << 6, {64'h2, 512'h2});
        do_read(16'h0a09, 64'd9 << 6, {64'h1, 512'h1});
    endtask

    task automatic test_reset_midflight();
        rready = 1'b0; bready = 1'b0;
        arid = 16'h00a1; araddr = 64'd7 << 6; arvalid = 1'b1;
        awid = 16'h00b1; awaddr = 64'd11 << 6; wtag = {8{8'hee}}; wdata = {64{8'hee}}; wsel = 2'b11;
        awvalid = 1'b1; wvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        arid = 16'h00a2; araddr = 64'd10 << 6;
        step();
        arvalid = 1'b0;
        for (int k = 0; k < 4; k++) step();
        @(negedge clk);
        total++;
        if ({rvalid, bvalid} !== 2'b11) begin bad++; $display("FAIL rst_pre: got %b want 11", {rvalid, bvalid}); end
        #1 rst = 1'b1;
        #1;
        total++;
        if ({arready, awready, wready, rvalid, bvalid} !== 5'b0) begin
            bad++; $display("FAIL rst_async_ctrl: got %b want 00000", {arready, awready, wready, rvalid, bvalid});
        end
        total++;
        if ({rid, bid, rdata} !== '0) begin bad++; $display("FAIL rst_async_data: rid=%h bid=%h nonzero", rid, bid); end
        step(); step();
        rst = 1'b0;
        rready = 1'b1; bready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            total++;
            if ({rvalid, bvalid} !== 2'b00) begin bad++; $display("FAIL rst_stale %0d: got %b want 00", k, {rvalid, bvalid}); end
            step();
        end
        rready = 1'b0; bready = 1'b0;
        do_read(16'h00c1, 64'd7 << 6, LINE55);
        do_read(16'h00c2, 64'd11 << 6, {72{8'hee}});
    endtask

    task automatic test_back_to_back();
        f_rready = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            if (k < 6) begin
                f_arid = ID_W'(16'h10 + k); f_araddr = ADDR_W'(k) << 6; f_arvalid = 1'b1;
            end else begin
                f_arvalid = 1'b0;
            end
            @(negedge clk);
            if (k < 6) begin
                total++;
                if (f_arready !== 1'b1) begin bad++; $display("FAIL b2b_arready %0d: got %b want 1", k, f_arready); end
            end
            total++;
            if (k == 0) begin
                if (f_rvalid !== 1'b0) begin bad++; $display("FAIL b2b_first: got %b want 0", f_rvalid); end
            end else if ({f_rvalid, f_rid} !== {1'b1, ID_W'(16'h10 + k - 1)}) begin
                bad++; $display("FAIL b2b_beat %0d: got %b/%h want 1/%h", k, f_rvalid, f_rid, 16'h10 + k - 1);
            end
            step();
        end
        @(negedge clk);
        total++;
        if (f_rvalid !== 1'b0) begin bad++; $display("FAIL b2b_drain: got %b want 0", f_rvalid); end
        step();
        f_rready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_field_write_latency();
        test_outstanding();
        test_same_cycle_rw();
        test_wsel_none();
        test_b_backpressure();
        test_reset_midflight();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
